// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP,
    ST_BRK
  } uart_state_e;

  localparam int   UART_NBYTES   = 4;
  localparam int   UART_DBITS    = 8;
  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level, with a configurable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the asynchronous input twice before anything else uses it.
  // NOTE: sequential state uses non-blocking (<=) so both flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_pkt4.sv
// Oversampling 8N1 receiver that assembles four bytes into one packet,
// with start/stop validation and an inter-byte gap timeout.
module uart_rx_pkt4
  import uart_pkg::*;
#(
  parameter int OVS    = 16,
  parameter int GAP_TO = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxck,
  input  logic       rxsd,
  output logic       rcv_done,
  output logic [7:0] rpd0,
  output logic [7:0] rpd1,
  output logic [7:0] rpd2,
  output logic [7:0] rpd3,
  output logic       frm_err,
  output logic       busy
);

  localparam int TW = $clog2(OVS) + 1;
  localparam int GW = $clog2(GAP_TO + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TO - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TO);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DBITS - 1);
  localparam logic [1:0]    IDX_LAST  = 2'(UART_NBYTES - 1);

  uart_state_e           state, state_next;
  logic                  sd;
  logic [TW-1:0]         tick_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [2:0]            bit_cnt;
  logic [1:0]            byte_idx;
  logic [UART_DBITS-1:0] shreg;
  logic [7:0]            byte_buf [UART_NBYTES-1];

  logic tick_clr, shift_en, byte_ok, pkt_done, err_pulse;

  uart_sync2 #(.RST_VAL(UART_IDLE_LVL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxsd),
    .q   (sd)
  );

  assign busy = (state != ST_IDLE) && (state != ST_BRK);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and per-tick control strobes; nothing moves without rxck.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    tick_clr   = 1'b0;
    shift_en   = 1'b0;
    byte_ok    = 1'b0;
    pkt_done   = 1'b0;
    err_pulse  = 1'b0;
    if (rxck) begin
      unique case (state)
        ST_IDLE: begin
          if (!sd) begin
            state_next = ST_START;
            tick_clr   = 1'b1;
          end
        end
        ST_START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_clr = 1'b1;
            if (!sd)                 state_next = ST_DATA;
            else if (byte_idx == '0) state_next = ST_IDLE;
            else                     state_next = ST_GAP;
          end
        end
        ST_DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_clr = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == BIT_LAST) state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick_cnt == FULL_LAST) begin
            tick_clr = 1'b1;
            if (sd) begin
              byte_ok = 1'b1;
              if (byte_idx == IDX_LAST) begin
                pkt_done   = 1'b1;
                state_next = ST_IDLE;
              end else begin
                state_next = ST_GAP;
              end
            end else begin
              err_pulse  = 1'b1;
              state_next = ST_BRK;
            end
          end
        end
        ST_GAP: begin
          if (!sd) begin
            state_next = ST_START;
            tick_clr   = 1'b1;
          end else if (gap_cnt >= GAP_LAST) begin
            err_pulse  = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (sd) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Tick, bit, gap and byte counters plus the data shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else if (rxck) begin
      tick_cnt <= tick_clr ? '0 : tick_cnt + 1'b1;
      if (shift_en) begin
        shreg   <= {sd, shreg[UART_DBITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state == ST_START) begin
        bit_cnt <= '0;
      end
      // Gap time is measured from the stop-bit sample and saturates.
      if (byte_ok)                 gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
      // Leaving the packet (done, timeout or break) restarts at byte 0.
      if (state_next == ST_IDLE || state_next == ST_BRK) byte_idx <= '0;
      else if (byte_ok)                                   byte_idx <= byte_idx + 1'b1;
    end
  end

  // Holding buffer for bytes 0..2 while the rest of the packet arrives.
  // NOTE: the buffer has no reset; it is always written before it is read out.
  always_ff @(posedge clk) begin
    if (byte_ok && byte_idx != IDX_LAST) byte_buf[byte_idx] <= shreg;
  end

  // Registered strobes and the packet outputs, loaded all at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcv_done <= 1'b0;
      frm_err  <= 1'b0;
      rpd0     <= '0;
      rpd1     <= '0;
      rpd2     <= '0;
      rpd3     <= '0;
    end else begin
      rcv_done <= pkt_done;
      frm_err  <= err_pulse;
      if (pkt_done) begin
        rpd0 <= byte_buf[0];
        rpd1 <= byte_buf[1];
        rpd2 <= byte_buf[2];
        rpd3 <= shreg;
      end
    end
  end

endmodule

// File: doc/uart_rx_pkt4.md
# uart_rx_pkt4

Oversampling 4-byte packet receiver for the UART link: recovers 8N1 frames from the serial line `rxsd`, validates start and stop bits, and presents each complete 4-byte packet on `rpd0`..`rpd3` with a one-cycle `rcv_done` strobe. It is the receiving end of the 4-byte packet transmitter. Unlike a 1x-tick receiver, it samples each bit at mid-bit using an oversampling enable, so it tolerates line skew and glitches. It also reports framing errors and inter-byte timeouts.

## Interface
- `OVS`, 16: `rxck` ticks per bit; legal range 4..64, even values only.
- `GAP_TO`, 160: maximum idle `rxck` ticks allowed between the stop-bit sample of one byte and the start edge of the next byte within a packet.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `rxck` input 1: oversample enable, one `clk` wide, `OVS` pulses per bit time.
- `rxsd` input 1: asynchronous serial line; idle level is high.
- `rcv_done` output 1: one-cycle pulse when a valid packet has been captured.
- `rpd0`..`rpd3` output 8 each: last good packet, byte 0 first on the wire; held until the next good packet.
- `frm_err` output 1: one-cycle pulse on a stop-bit error or a gap timeout.
- `busy` output 1: high while a packet is in progress (any state other than IDLE or BRK).

## Operation
- **Input synchronizer:** `rxsd` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `sd`.
- **Frame format:** start bit 0, 8 data bits LSB first, stop bit 1. Bytes arrive in order `rpd0`, `rpd1`, `rpd2`, `rpd3`.
- **IDLE:** `byte_idx` = 0. On an `rxck` tick with `sd` = 0, go to START and clear the tick counter.
- **START:** count `OVS/2` ticks, then resample.
  - `sd` = 0: go to DATA.
  - `sd` = 1: false start; return to IDLE (if `byte_idx` = 0) or to GAP (otherwise). The gap counter keeps running.
- **DATA:** sample every `OVS` ticks and shift right into `shreg[7:0]`, so the MSB enters last. After 8 samples, go to STOP.
- **STOP:** sample after `OVS` ticks.
  - `sd` = 1: write `shreg` into `buf[byte_idx]`.
    - If `byte_idx` = 3: load all of `rpd0`..`rpd3` from `buf` together, pulse `rcv_done`, go to IDLE.
    - Otherwise: increment `byte_idx`, go to GAP.
  - `sd` = 0: pulse `frm_err`, discard the partial packet, go to BRK.
- **GAP:** count `rxck` ticks.
  - `sd` = 0 on a tick: go to START.
  - Count reaches `GAP_TO`: pulse `frm_err`, discard the partial packet, go to IDLE.
- **BRK:** wait for `sd` = 1 on an `rxck` tick, then go to IDLE.
- **Outputs on error:** `rpd*` are never partially updated. After any error they keep the previous good packet.
- **Counter widths:**
  - tick counter: `$clog2(OVS)+1` bits.
  - gap counter: `$clog2(GAP_TO+1)` bits; saturates, never wraps.
  - bit counter: 3 bits; `byte_idx`: 2 bits.

## Timing
- **Reset values:** `rcv_done`=0, `frm_err`=0, `busy`=0, `rpd0`..`rpd3`=8'h00, state IDLE, synchronizer=1.
- **Reset mid-frame:** takes effect at the next edge. Any partial packet is discarded with no `frm_err`.
- **Input latency:** 2 `clk` from `rxsd` to `sd`. Sampling happens only on cycles where `rxck`=1.
- **Output timing:** `rcv_done`, `frm_err` and `rpd*` are registered. They update on the `clk` edge that ends the `rxck` cycle in which the deciding sample is taken.
- **Sample points:**
  - start at `OVS/2` ticks after the falling edge is detected;
  - data bit k at `OVS/2 + (k+1)*OVS`;
  - stop at `OVS/2 + 9*OVS`.
- **Return to IDLE:** occurs half a bit before the nominal end of the stop bit, so back-to-back packets with zero idle are received.
- **Output exclusivity:** `rcv_done` and `frm_err` are never high in the same cycle.
- **`rxck` = 0:** the FSM holds state; nothing advances without ticks.

## Structure
- **Shared package `uart_pkg`:**
  - state enum (IDLE, START, DATA, STOP, GAP, BRK);
  - `UART_NBYTES` = 4;
  - `UART_DBITS` = 8;
  - `UART_IDLE_LVL` = 1'b1.
- **Sub-module `uart_sync2`:** 2-flop synchronizer, reset value parameterized. It is reusable by other UART blocks.
- **Top level:** the FSM, counters and byte buffer stay in the top level.

## Test plan
- **Good packet:** `OVS`=16, one `rxck` every 4 `clk`. Send A5, 3C, 00, FF back-to-back -> exactly one `rcv_done`; `rpd0`..`rpd3` = A5, 3C, 00, FF; `frm_err` never high.
- **Glitch rejection:** drive `rxsd` low for 3 `rxck` ticks, then high -> no state change beyond START; `busy` drops; no `rcv_done` or `frm_err`. A following packet 11, 22, 33, 44 is received correctly.
- **Stop-bit error:** force stop bit = 0 on byte 1 -> `frm_err` pulses once; no `rcv_done`; `rpd*` keep the previous packet. Hold the line low 20 bits, release, send 55, 66, 77, 88 -> received correctly.
- **Gap timeout:** send 2 bytes, idle for 161 ticks -> `frm_err` at tick 160. A new 4-byte packet is then received from `byte_idx` 0.
- **Reset mid-packet:** assert `rst` for 1 cycle during byte 2 -> all outputs read 0 on the next cycle; no `frm_err`. A following packet 01, 02, 03, 04 is received correctly.
- **Baud skew:** transmit at ±3% bit-period skew with `OVS`=16 -> 100 random packets all received correctly.
